// File: rtl/pipemux_pkg.sv
// Shared constants and helpers for the pipelined mux/demux trees.
// Provides clog2w() and the default phit width / port count.
package pipemux_pkg;

  localparam int PIPEMUX_WIDTH = 72;
  localparam int PIPEMUX_N     = 4;

  // Index width that never collapses to zero bits.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipedemux_fifo.sv
// Per-port FIFO with a head-registered output.
// Ports: CLK, RST, push, wdata, full, pop, rdata, empty.
module pipedemux_fifo
  import pipemux_pkg::*;
#(
  parameter int WIDTH = PIPEMUX_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int AW = clog2w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head entry is read straight from storage registers.
  assign rdata   = mem[rptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pipedemux_prim.sv
// Steers one phit stream to N leaf FIFOs, unicast or broadcast.
// Ports: CLK/RST, data/dest/bcast/valid in, ready_out, per-port data/valid out, ready_in, dest_err.
module pipedemux_prim
  import pipemux_pkg::*;
#(
  parameter int WIDTH = PIPEMUX_WIDTH,
  parameter int N     = PIPEMUX_N,
  parameter int DEPTH = 2,
  localparam int DW   = clog2w(N)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] data_in,
  input  logic [DW-1:0]    dest_in,
  input  logic             bcast_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] data_out [N-1:0],
  output logic [N-1:0]     valid_out,
  input  logic [N-1:0]     ready_in,
  output logic             dest_err
);

  logic [N-1:0] full;
  logic [N-1:0] empty;
  logic [N-1:0] sel;
  logic [N-1:0] push;
  logic         dest_ok;
  logic         accept;

  assign dest_ok = (32'(dest_in) < N);
  assign accept  = valid_in & ready_out;

  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      sel[i] = bcast_in | (dest_in == DW'(i));
    end
  end

  // Only registered full flags feed ready_out, so ready_in never
  // reaches it; an out-of-range unicast is swallowed.
  always_comb begin
    ready_out = 1'b1;
    if (bcast_in) begin
      ready_out = ~|full;
    end else if (dest_ok) begin
      ready_out = ~|(full & sel);
    end
  end

  assign push = accept ? sel : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dest_err <= 1'b0;
    end else if (accept & ~bcast_in & ~dest_ok) begin
      dest_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_port
    pipedemux_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push[g]),
      .wdata (data_in),
      .full  (full[g]),
      .pop   (ready_in[g]),
      .rdata (data_out[g]),
      .empty (empty[g])
    );
    assign valid_out[g] = ~empty[g];
  end

endmodule

// File: tb/tb_pipedemux_prim.sv
// Scoreboard bench for pipedemux_prim (N=6, DEPTH=2).
// Driver pushes expected phits per port; monitor pops and compares.
module tb_pipedemux_prim;

  localparam int W  = 72;
  localparam int N  = 6;
  localparam int D  = 2;
  localparam int DW = 3;

  logic          clk;
  logic          rst;
  logic [W-1:0]  data_in;
  logic [DW-1:0] dest_in;
  logic          bcast_in;
  logic          valid_in;
  logic          ready_out;
  logic [W-1:0]  data_out [N-1:0];
  logic [N-1:0]  valid_out;
  logic [N-1:0]  ready_in;
  logic          dest_err;

  pipedemux_prim #(.WIDTH(W), .N(N), .DEPTH(D)) dut (
    .CLK       (clk),
    .RST       (rst),
    .data_in   (data_in),
    .dest_in   (dest_in),
    .bcast_in  (bcast_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .dest_err  (dest_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp  = 0;
  int errs = 0;

  logic [W-1:0] sb [N][$];
  int           occ [N];
  bit           err_m;
  bit           last_acc;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented head must be the oldest outstanding phit.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("valid_out[%0d]", i), W'(valid_out[i]),
            W'(sb[i].size() != 0));
        if (sb[i].size() != 0) begin
          if (valid_out[i])
            chk($sformatf("data_out[%0d]", i), data_out[i], sb[i][0]);
          if (ready_in[i]) void'(sb[i].pop_front());
        end
      end
    end
  end

  // One cycle: drive at posedge+1, judge the handshake at negedge+1.
  task automatic step(bit v, bit b, int d, logic [W-1:0] dat,
                      logic [N-1:0] rdy);
    bit exp_rdy;
    bit acc;
    valid_in = v;
    bcast_in = b;
    dest_in  = DW'(d);
    data_in  = dat;
    ready_in = rdy;
    @(negedge clk);
    #1;
    if (b) begin
      exp_rdy = 1'b1;
      for (int i = 0; i < N; i++) if (occ[i] == D) exp_rdy = 1'b0;
    end else if (d >= N) begin
      exp_rdy = 1'b1;
    end else begin
      exp_rdy = (occ[d] < D);
    end
    chk("ready_out", W'(ready_out), W'(exp_rdy));
    chk("dest_err", W'(dest_err), W'(err_m));
    acc = v && exp_rdy;
    for (int i = 0; i < N; i++) begin
      bit pp = (occ[i] > 0) && rdy[i];
      bit ps = acc && (b || d == i);
      if (ps) sb[i].push_back(dat);
      occ[i] = occ[i] + int'(ps) - int'(pp);
    end
    if (acc && !b && d >= N) err_m = 1'b1;
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic send(bit b, int d, logic [W-1:0] dat, logic [N-1:0] rdy);
    int n = 0;
    do begin
      step(1'b1, b, d, dat, rdy);
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) begin
      cmp++;
      errs++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
  endtask

  task automatic idle(int n, logic [N-1:0] rdy);
    repeat (n) step(1'b0, 1'b0, 0, '0, rdy);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      sb[i].delete();
      occ[i] = 0;
    end
    err_m = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    bcast_in = 1'b0;
    dest_in  = '0;
    data_in  = '0;
    ready_in = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_out", W'(valid_out), '0);
    chk("rst_dest_err", W'(dest_err), '0);
    for (int i = 0; i < N; i++)
      chk($sformatf("rst_data_out[%0d]", i), data_out[i], '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Unicast with one-cycle latency.
    step(1'b1, 1'b0, 2, W'(72'hA1), '1);
    chk("lat_valid", W'(valid_out), W'(6'b000100));
    chk("lat_data", data_out[2], W'(72'hA1));
    idle(2, '1);

    // Backpressure on port 1: third phit waits.
    step(1'b1, 1'b0, 1, W'(72'h11), 6'b111101);
    step(1'b1, 1'b0, 1, W'(72'h12), 6'b111101);
    step(1'b1, 1'b0, 1, W'(72'h13), 6'b111101);
    step(1'b1, 1'b0, 1, W'(72'h13), 6'b111101);
    send(1'b0, 1, W'(72'h13), '1);
    idle(4, '1);

    // Broadcast blocked by a full port 3.
    send(1'b0, 3, W'(72'h31), 6'b110111);
    send(1'b0, 3, W'(72'h32), 6'b110111);
    step(1'b1, 1'b1, 0, W'(72'hBB), 6'b110111);
    send(1'b1, 0, W'(72'hBB), '1);
    idle(4, '1);

    // Highest legal index, then an illegal one.
    send(1'b0, 5, W'(72'h55), '1);
    send(1'b0, 7, W'(72'h77), '1);
    idle(3, '1);
    send(1'b0, 6, W'(72'h66), '1);
    idle(2, '1);

    // Sustained round-robin stream.
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0, k % 4, W'(k + 72'h100), '1);
      chk("rr_accept", W'(last_acc), W'(1));
    end
    idle(3, '1);

    // Reset with data held in ports 0 and 2.
    send(1'b0, 0, W'(72'hC0), '0);
    send(1'b0, 2, W'(72'hC2), '0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid_out", W'(valid_out), '0);
    chk("async_dest_err", W'(dest_err), '0);
    clear_model();
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 0, W'(72'hD0), '1);
    chk("post_rst_valid", W'(valid_out), W'(6'b000001));
    chk("post_rst_data", data_out[0], W'(72'hD0));
    idle(2, '1);

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      logic [W-1:0] dat;
      dat = {$urandom, $urandom, 8'($urandom)};
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7), dat, N'($urandom));
    end
    idle(6, '1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
